inst_prefetch_queue: RTL
========================

INST_PREFETCH_QUEUE -- requirements
Module: inst_prefetch_queue

Interface
REQ-001 Parameter DEPTH, default 4: queue entries, power of two, 2..16.
REQ-002 Parameter PC_W, default 8: program-counter width, word-indexed ROM address.
REQ-003 Parameter RESET_PC, default 0: first fetch address after reset.
REQ-004 Clocking: one clock; reset is synchronous and active-high.
REQ-005 Port clk  input  1  rising-edge clock for all state.
REQ-006 Port rst  input  1  synchronous active-high reset.
REQ-007 Port redirect  input  1  taken branch or jump; flushes the queue.
REQ-008 Port redirect_pc  input  PC_W  new fetch address, valid when redirect=1.
REQ-009 Port rom_addr  output  PC_W  address to the instruction ROM.
REQ-010 Port rom_instr  input  32  ROM data, combinational from rom_addr in the same cycle.
REQ-011 Port out_valid  output  1  head entry present for decode.
REQ-012 Port out_ready  input  1  decode accepts the head entry; low means decode is stalled.
REQ-013 Port out_pc  output  PC_W  PC of the head entry.
REQ-014 Port out_instr  output  32  instruction of the head entry.
REQ-015 Port full  output  1  count == DEPTH.
REQ-016 Port empty  output  1  count == 0.

Function
REQ-017 State: fetch_pc register, circular storage of DEPTH {pc, instr} entries, head and tail pointers, and count (0..DEPTH).
REQ-018 rom_addr = fetch_pc, driven combinationally.
REQ-019 Push condition: redirect=0 and count < DEPTH.
- On push, {fetch_pc, rom_instr} is written at tail.
- tail advances modulo DEPTH.
- fetch_pc increments by 1 modulo 2^PC_W.
REQ-020 When count == DEPTH, there is no push and fetch_pc holds, even if a pop occurs in the same cycle.
REQ-021 Pop condition: out_valid=1, out_ready=1 and redirect=0. On pop, head advances modulo DEPTH.
REQ-022 Count update on a cycle with both push and pop: count is unchanged.
REQ-023 Count update otherwise: +1 on push only, -1 on pop only.
REQ-024 out_valid = (count != 0). out_pc and out_instr are read combinationally from head.
REQ-025 When out_valid=0, out_instr shall be 32'h0 (NOP) and out_pc shall be 0.
REQ-026 Latency: an instruction fetched in cycle N is visible at the output in cycle N+1. Steady-state throughput is one instruction per cycle.
REQ-027 Redirect has priority over push and pop.
- Next cycle: count=0, head=tail=0, fetch_pc=redirect_pc.
- The ROM word read in the redirect cycle is discarded.
- The head presented in the redirect cycle counts as squashed; out_ready is ignored in that cycle.
REQ-028 After a redirect, the first instruction from the new address appears at the output 2 cycles after redirect was asserted.
REQ-029 Back-to-back redirects: the last one wins; no entries are pushed between them.
REQ-030 A redirect while empty or full behaves identically to REQ-027.
REQ-031 No entry is ever overwritten before it is popped or flushed. No entry is ever output twice.

Reset
REQ-032 When rst=1 at a clock edge, the following take effect on that edge:
- fetch_pc=RESET_PC, count=0, head=tail=0.
- out_valid=0, empty=1, full=0, out_instr=0, out_pc=0.
REQ-033 rst has priority over redirect, push and pop. Queue contents are invalidated regardless of prior state.
REQ-034 In the first cycle after rst deasserts, rom_addr=RESET_PC and a push occurs.

Verification
REQ-035 Streaming:
- Stimulus: reset, then out_ready=1 and redirect=0 constantly.
- Response: out_pc is 0,1,2,3,... one per cycle, starting the cycle after the first push; rom_instr values match in order.
REQ-036 Fill while stalled:
- Stimulus: reset, then out_ready=0 for 6 cycles.
- Response: full=1 after 4 pushes, rom_addr holds at 4, out_pc stays at 0.
- Stimulus: raise out_ready.
- Response: out_pc 0,1,2,3,4,... with no gaps or duplicates.
REQ-037 Flush:
- Stimulus: with count=3, assert redirect with redirect_pc=0x40 for one cycle.
- Response: next cycle empty=1, out_valid=0, rom_addr=0x40; the following cycle out_valid=1, out_pc=0x40.
REQ-038 Simultaneous push and pop:
- Stimulus: count=3, out_ready=1.
- Response: count remains 3 and the output sequence stays contiguous.
REQ-039 Address wrap:
- Stimulus: redirect to 0xFE, out_ready=1.
- Response: out_pc is 0xFE, 0xFF, 0x00, 0x01.
REQ-040 Reset mid-operation:
- Stimulus: assert rst for one cycle while full with out_ready=1 and redirect=1, redirect_pc=0x20.
- Response: next cycle out_valid=0 and rom_addr=0x00; redirect is ignored.

Source files
------------

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: fetches sequential ROM words into a small FIFO
// ahead of decode, flushing on redirect.
module inst_prefetch_queue #(
  parameter int              DEPTH    = 4,
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic [PC_W-1:0] rom_addr,
  input  logic [31:0]     rom_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic            full,
  output logic            empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] LP_FULL = CNT_W'(DEPTH);

  logic [PC_W-1:0]  r_fetch_pc;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic [PC_W-1:0]  r_pc_mem [DEPTH];
  logic [31:0]      r_instr_mem [DEPTH];

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == LP_FULL);
  assign w_empty = (r_count == '0);

  // A full queue never pushes, even when the head leaves this cycle.
  assign w_push = !redirect && !w_full;
  assign w_pop  = !redirect && !w_empty && out_ready;

  assign rom_addr  = r_fetch_pc;
  assign full      = w_full;
  assign empty     = w_empty;
  assign out_valid = !w_empty;
  assign out_pc    = w_empty ? '0 : r_pc_mem[r_head];
  assign out_instr = w_empty ? 32'h0 : r_instr_mem[r_head];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else if (redirect) begin
      r_fetch_pc <= redirect_pc;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else begin
      if (w_push) begin
        r_fetch_pc <= r_fetch_pc + PC_W'(1);
        r_tail     <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
      unique case (1'b1)
        (w_push && !w_pop): r_count <= r_count + CNT_W'(1);
        (w_pop && !w_push): r_count <= r_count - CNT_W'(1);
        default:            r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset; validity is tracked by r_count.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_pc_mem[r_tail]    <= r_fetch_pc;
      r_instr_mem[r_tail] <= rom_instr;
    end
  end

endmodule
